// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the serialiser state encoding.
package bus_uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Synchronous TX FIFO; a push while full is accepted only when a pop frees a slot
// in the same cycle, otherwise the caller sees it dropped.
module tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Pointers are AW bits wide so they wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register file, bus decode, TX FIFO and a
// baud-timed serialiser with a level TX-done interrupt.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        tx,
  output logic        irq
);

  localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

  logic [15:0]               r_div;
  logic                      r_en;
  logic                      r_ie;
  logic                      r_ovf;
  tx_state_t                 r_state;
  logic [15:0]               r_cnt;
  logic [15:0]               r_bitdiv;
  logic [7:0]                r_shift;
  logic [2:0]                r_bit;
  logic                      r_tx;
  logic                      r_irq;

  logic [1:0]                w_reg;
  logic                      w_wr;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [7:0]                w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                      w_bit_end;
  logic [31:0]               w_rdata;
  logic                      w_unused;

  assign w_reg     = addr[3:2];
  assign w_wr      = sel && we;
  assign w_push    = w_wr && (w_reg == REG_DATA);
  assign w_pop     = (r_state == S_IDLE) && r_en && !w_empty;
  assign w_bit_end = (r_cnt == r_bitdiv - 16'd1);
  assign w_unused  = &{1'b0, func3, addr[31:4], addr[1:0], wData[31:16]};

  tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (wData[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DIV_INIT;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      // A full-FIFO push is only lost when the serialiser is not popping this cycle.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && (w_reg == REG_STATUS) && wData[ST_OVF]) r_ovf <= 1'b0;
      if (w_wr && (w_reg == REG_BAUDDIV))
        r_div <= (wData[15:0] == 16'd0) ? 16'd1 : wData[15:0];
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_en <= wData[CTRL_EN];
        r_ie <= wData[CTRL_IE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_cnt    <= '0;
      r_bitdiv <= DIV_INIT;
      r_shift  <= '0;
      r_bit    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= r_ie && w_empty && (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= w_head;
            r_bitdiv <= r_div;
            r_cnt    <= '0;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (sel) begin
      case (w_reg)
        REG_STATUS: begin
          w_rdata[ST_FULL]            = w_full;
          w_rdata[ST_EMPTY]           = w_empty;
          w_rdata[ST_BUSY]            = (r_state != S_IDLE);
          w_rdata[ST_OVF]             = r_ovf;
          w_rdata[ST_COUNT_LSB +: 8]  = 8'(w_count);
        end
        REG_BAUDDIV: w_rdata[15:0] = r_div;
        REG_CTRL: begin
          w_rdata[CTRL_EN] = r_en;
          w_rdata[CTRL_IE] = r_ie;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign rData = w_rdata;
  assign tx    = r_tx;
  assign irq   = r_irq;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register access, frame decoding from the
// serial line, FIFO full/overflow behaviour, interrupt timing and async reset.
module tb_bus_uart_tx;

  localparam int FD = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_BAUD = 2'd2, A_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, we;
  logic [2:0]  func3;
  logic [31:0] addr, wData, rData;
  logic        tx, irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bus_uart_tx #(.FIFO_DEPTH(FD), .DIV_RESET(868)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .func3(func3),
    .addr(addr), .wData(wData), .rData(rData), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr_sz(input logic [1:0] r, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; func3 = f; wData = d;
    addr = ($urandom & 32'hFFFF_FFF0) | {28'h0, r, 2'b00};
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    wr_sz(r, d, 3'b010);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; func3 = 3'b010;
    addr = ($urandom & 32'hFFFF_FFF0) | {28'h0, r, 2'b00};
    #1 v = rData;
    sel = 1'b0;
  endtask

  function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit busy);
    stat = (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(busy) << 2) |
           (32'(cnt == 0) << 1) | 32'(cnt == FD);
  endfunction

  // Waits for a start bit, then records the whole frame one sample per cycle and
  // checks that every bit period is exactly div cycles long.
  task automatic wait_frame(input int div, output logic [7:0] b, output int tf);
    bit smp[$];
    int bad;
    bit seen;
    b = '0; tf = -1; seen = 1'b0; bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin seen = 1'b1; break; end
    end
    chk("frame_start_seen", 32'(seen), 32'd1);
    if (seen) begin
      tf = cyc;
      smp.push_back(tx);
      for (int k = 1; k < 10*div; k++) begin
        @(negedge clk);
        smp.push_back(tx);
      end
      for (int k = 0; k < 10*div; k++)
        if (smp[k] != smp[(k/div)*div]) bad++;
      if (smp[0] != 1'b0) bad++;
      if (smp[9*div] != 1'b1) bad++;
      for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*div];
      chk("frame_shape", 32'(bad), 32'd0);
    end
  endtask

  task automatic run_batch(input int div, input int n, input bit fixed);
    logic [7:0]  q[$];
    logic [7:0]  d, b;
    logic [31:0] v;
    bit          ovf;
    int          tf, prev, low;
    ovf = 1'b0;
    wr(A_BAUD, 32'(div));
    wr(A_CTRL, 32'd0);
    for (int i = 0; i < n; i++) begin
      d = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
      v = $urandom;
      v[7:0] = d;
      wr_sz(A_DATA, v, 3'($urandom_range(0, 2)));
      if (q.size() < FD) q.push_back(d);
      else ovf = 1'b1;
    end
    rd(A_STATUS, v);
    chk("status_filled", v, stat(q.size(), ovf, 1'b0));
    if (ovf) begin
      wr(A_STATUS, 32'h8);
      rd(A_STATUS, v);
      chk("status_ovf_clr", v, stat(q.size(), 1'b0, 1'b0));
    end
    wr(A_CTRL, 32'd1);
    prev = 0;
    for (int i = 0; i < q.size(); i++) begin
      wait_frame(div, b, tf);
      chk("frame_byte", 32'(b), 32'(q[i]));
      if (i > 0) chk("frame_gap", 32'(tf - prev), 32'(10*div + 1));
      prev = tf;
    end
    low = 0;
    repeat (12*div + 4) begin
      @(negedge clk);
      if (tx == 1'b0) low++;
    end
    chk("no_extra_frame", 32'(low), 32'd0);
    rd(A_STATUS, v);
    chk("status_drained", v, 32'h2);
    wr(A_CTRL, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b, a5;
    int          tf, m, target, low;
    bit          exp_bit;

    rst = 1'b0; sel = 1'b0; we = 1'b0; func3 = 3'b0; addr = '0; wData = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;

    rd(A_STATUS, v);  chk("rst_status", v, 32'h2);
    rd(A_BAUD, v);    chk("rst_bauddiv", v, 32'h364);
    rd(A_CTRL, v);    chk("rst_ctrl", v, 32'h0);
    addr = {28'h0, A_STATUS, 2'b00};
    #1 chk("rdata_nosel", rData, 32'h0);

    // Single 0xA5 frame, cycle-exact against the 8N1 definition.
    a5 = 8'hA5;
    wr(A_BAUD, 32'd4);
    wr(A_CTRL, 32'd1);
    wr_sz(A_DATA, 32'hFFFF_FFA5, 3'b000);
    chk("t2_idle_before", 32'(tx), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = a5[(k - 4) / 4];
      else             exp_bit = 1'b1;
      chk($sformatf("t2_tx_%0d", k), 32'(tx), 32'(exp_bit));
    end
    rd(A_STATUS, v);
    chk("t2_not_busy", v, 32'h2);

    run_batch(4, 9, 1'b1);
    for (int r = 0; r < 4; r++)
      run_batch($urandom_range(1, 6), $urandom_range(1, 12), 1'b0);

    wr(A_BAUD, 32'd0);
    rd(A_BAUD, v);
    chk("bauddiv_zero", v, 32'h1);
    wr(A_CTRL, 32'd1);
    wr_sz(A_DATA, 32'h1234_5678, 3'b000);
    wait_frame(1, b, tf);
    chk("sb_low_byte", 32'(b), 32'h78);

    wr(A_BAUD, 32'd4);
    wr(A_CTRL, 32'd3);
    @(negedge clk);
    chk("irq_idle_empty", 32'(irq), 32'd1);
    wr(A_DATA, 32'h5A);
    wait_frame(4, b, tf);
    chk("irq_frame_byte", 32'(b), 32'h5A);
    @(negedge clk);
    chk("irq_at_idle", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 32'd1);

    wr(A_DATA, 32'hF0);
    m = cyc;
    wr(A_DATA, 32'h0F);
    chk("irq_drop", 32'(irq), 32'd0);
    chk("t6_start_bit", 32'(tx), 32'd0);
    target = m + 18;
    for (int i = 0; i < 100 && cyc < target; i++) @(negedge clk);
    chk("t6_bit3_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1 chk("t6_async_tx", 32'(tx), 32'd1);
    chk("t6_async_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(A_STATUS, v);  chk("t6_status", v, 32'h2);
    rd(A_CTRL, v);    chk("t6_ctrl", v, 32'h0);
    rd(A_BAUD, v);    chk("t6_bauddiv", v, 32'h364);
    wr(A_CTRL, 32'd1);
    low = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx == 1'b0) low++;
    end
    chk("t6_no_residual", 32'(low), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
Memory-mapped UART transmitter; a responder on the CPU data bus (busWe/busAddr/busWData/busRData/busFunc3), next to RAM.
- CPU stores bytes into a TX FIFO.
- A baud-rate FSM serialises them 8N1, LSB first, on `tx`.
- Status and interrupt let firmware poll or sleep.
- Address decode selecting this block is external and arrives as `sel`.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- DIV_RESET, 868, reset value of BAUDDIV, in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- sel  input  1  this peripheral is addressed this cycle.
- we  input  1  bus write enable (busWe).
- func3  input  3  access size (busFunc3): 000 byte, 001 half, 010 word; loads 100/101 unsigned.
- addr  input  32  bus address; only addr[3:2] decoded.
- wData  input  32  bus write data.
- rData  output  32  combinational read data; 0 when sel=0.
- tx  output  1  serial line, idle high, registered.
- irq  output  1  TX-done interrupt, level.

Behaviour:
- Register map (addr[3:2]):
  - 0 DATA: write pushes wData[7:0] for any func3; reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] count; other bits 0.
    - Write with wData[3]=1 clears overflow; other bits are ignored.
  - 2 BAUDDIV: RW, bits[15:0].
    - Write of 0 stores 1. Upper bits read 0.
  - 3 CTRL: RW. bit0 en, bit1 ie; other bits read 0.
- Writes take effect at posedge when sel && we. Reads have no side effects.
- Reset (rst=0, asynchronous):
  - tx=1, FIFO empty, overflow=0, BAUDDIV=DIV_RESET, CTRL=0, FSM IDLE, irq=0.
  - STATUS reads 0x0000_0002.
- FIFO:
  - Push on a DATA write.
  - Push when full is dropped and sets overflow; the FIFO is unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty cannot occur, because pop requires non-empty.
  - Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - If en && !empty: pop head into shift register, latch BAUDDIV into bit-period register, go START.
    - tx falls at this edge, so a write at edge N with en set and FSM idle makes tx low at edge N+1.
  - START: tx=0 for DIV cycles, then go DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, shift right, index 0..7. After bit 7 go STOP.
  - STOP: tx=1 for DIV cycles, then go IDLE.
  - Back-to-back frames: exactly one extra idle-high cycle between STOP end and the next START.
- Frame length: 10*DIV cycles.
- BAUDDIV writes mid-frame affect only the next frame.
- Clearing en mid-frame: the current frame completes and no further pops occur.
- irq = ie && empty && FSM==IDLE, registered (one cycle after the condition).
- Reset mid-frame: tx=1 immediately, the frame is aborted and the FIFO is flushed.

Decomposition:
- Package bus_uart_pkg:
  - Register offset constants (DATA/STATUS/BAUDDIV/CTRL).
  - STATUS/CTRL bit-index constants.
  - FSM state enum typedef.
- Sub-module tx_fifo: synchronous FIFO with push/pop/full/empty/count and a DEPTH parameter.
  - Top level holds the register file, bus decode, baud counter and FSM.

Test Plan:
1. Reset -> tx=1, irq=0. Read STATUS=0x0000_0002, BAUDDIV=0x0000_0364, CTRL=0.
2. BAUDDIV=4, CTRL=1, SW DATA=0xA5 at edge N -> tx low from edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles; busy clears after 40 cycles.
3. CTRL=0, nine SB writes 0x01..0x09 -> STATUS count=8, full=1, overflow=1.
   - Write STATUS 0x8 -> overflow=0.
   - Set CTRL=1 -> frames 0x01..0x08 back-to-back with one-cycle gap; 0x09 is never sent.
4. SW BAUDDIV=0 -> reads 1. SB DATA with wData=0x1234_5678 -> transmitted byte is 0x78.
5. CTRL=3, one byte sent -> irq rises one cycle after the FSM returns to IDLE with the FIFO empty; a further DATA write drops irq.
6. Assert rst during DATA bit 3 -> tx=1 asynchronously, STATUS=0x2 after release, no residual frame.
